branch_target_predictor: RTL and testbench

//   Direct-mapped BTB plus 2-bit saturating-counter BHT for the branch-prediction pipeline core.

---
 rtl/branch_target_predictor.sv | 116 +++++++++++
 tb/tb_branch_target_predictor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_predictor
// Brief    : Direct-mapped BTB with 2-bit saturating BHT, EX-side mispredict
//            detection and saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             pred_taken_o,
    output logic [XLEN-1:0]  pred_target_o,
    input  logic             ex_valid_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic             ex_taken_i,
    input  logic [XLEN-1:0]  ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic [XLEN-1:0]  ex_pred_target_i,
    output logic             ex_mispredict_o,
    output logic [XLEN-1:0]  ex_redirect_pc_o,
    output logic [CNT_W-1:0] stat_branches_o,
    output logic [CNT_W-1:0] stat_mispredicts_o
);

    localparam int              c_IDX_W   = $clog2(ENTRIES);
    localparam int              c_TAG_W   = XLEN - c_IDX_W - 2;
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    logic [ENTRIES-1:0] r_valid;
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [1:0]         r_cnt    [ENTRIES];
    logic [CNT_W-1:0]   r_branches;
    logic [CNT_W-1:0]   r_mispredicts;

    logic [c_IDX_W-1:0] w_if_idx;
    logic [c_TAG_W-1:0] w_if_tag;
    logic               w_if_hit;
    logic [c_IDX_W-1:0] w_ex_idx;
    logic [c_TAG_W-1:0] w_ex_tag;
    logic               w_ex_hit;
    logic [1:0]         w_cnt_next;
    logic               w_unused_pc_bits;

    assign w_if_idx = if_pc_i[c_IDX_W+1:2];
    assign w_if_tag = if_pc_i[XLEN-1:c_IDX_W+2];
    assign w_ex_idx = ex_pc_i[c_IDX_W+1:2];
    assign w_ex_tag = ex_pc_i[XLEN-1:c_IDX_W+2];
    assign w_unused_pc_bits = ^{if_pc_i[1:0], ex_pc_i[1:0]};

    // Reads see only committed table state, so a same-cycle EX write to the
    // same index is not forwarded to IF.
    assign w_if_hit      = rstn && r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign pred_taken_o  = w_if_hit && r_cnt[w_if_idx][1];
    assign pred_target_o = pred_taken_o ? r_target[w_if_idx] : (if_pc_i + c_PC_STEP);

    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    always_comb begin
        w_cnt_next = r_cnt[w_ex_idx];
        if (ex_taken_i) begin
            if (r_cnt[w_ex_idx] != 2'b11) w_cnt_next = r_cnt[w_ex_idx] + 2'd1;
        end else begin
            if (r_cnt[w_ex_idx] != 2'b00) w_cnt_next = r_cnt[w_ex_idx] - 2'd1;
        end
    end

    assign ex_mispredict_o  = ex_valid_i &&
                              ((ex_pred_taken_i != ex_taken_i) ||
                               (ex_taken_i && (ex_pred_target_i != ex_target_i)));
    assign ex_redirect_pc_o = ex_taken_i ? ex_target_i : (ex_pc_i + c_PC_STEP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= 2'b01;
            end
        end else if (ex_valid_i) begin
            if (w_ex_hit) begin
                r_cnt[w_ex_idx] <= w_cnt_next;
                if (ex_taken_i) r_target[w_ex_idx] <= ex_target_i;
            end else if (ex_taken_i) begin
                // Allocation evicts whatever alias occupied the slot.
                r_valid[w_ex_idx]  <= 1'b1;
                r_tag[w_ex_idx]    <= w_ex_tag;
                r_target[w_ex_idx] <= ex_target_i;
                r_cnt[w_ex_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_branches    <= '0;
            r_mispredicts <= '0;
        end else begin
            if (ex_valid_i && (r_branches != '1))
                r_branches <= r_branches + CNT_W'(1);
            if (ex_mispredict_o && (r_mispredicts != '1))
                r_mispredicts <= r_mispredicts + CNT_W'(1);
        end
    end

    assign stat_branches_o    = r_branches;
    assign stat_mispredicts_o = r_mispredicts;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_target_predictor
// Brief    : Directed scoreboard bench for branch_target_predictor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

    localparam int c_K_PT = 0;
    localparam int c_K_TG = 1;
    localparam int c_K_MP = 2;
    localparam int c_K_RD = 3;
    localparam int c_K_SB = 4;
    localparam int c_K_SM = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    branch_target_predictor #(.XLEN(32), .ENTRIES(64), .CNT_W(32)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .if_pc_i            (if_pc),
        .pred_taken_o       (pred_taken),
        .pred_target_o      (pred_target),
        .ex_valid_i         (ex_valid),
        .ex_pc_i            (ex_pc),
        .ex_taken_i         (ex_taken),
        .ex_target_i        (ex_target),
        .ex_pred_taken_i    (ex_pred_taken),
        .ex_pred_target_i   (ex_pred_target),
        .ex_mispredict_o    (ex_mispredict),
        .ex_redirect_pc_o   (ex_redirect_pc),
        .stat_branches_o    (stat_branches),
        .stat_mispredicts_o (stat_mispredicts)
    );

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            c_K_PT:  observe = {31'd0, pred_taken};
            c_K_TG:  observe = pred_target;
            c_K_MP:  observe = {31'd0, ex_mispredict};
            c_K_RD:  observe = ex_redirect_pc;
            c_K_SB:  observe = stat_branches;
            default: observe = stat_mispredicts;
        endcase
    endfunction

    // Monitor: everything queued during a cycle is compared at the falling edge.
    always @(negedge clk) begin
        chk_t        item;
        logic [31:0] act;
        while (sb.size() > 0) begin
            item = sb.pop_front();
            act  = observe(item.kind);
            n_checks++;
            if (act !== item.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", item.name, act, item.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int kind, input logic [31:0] e);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = e;
        sb.push_back(c);
    endtask

    task automatic expect_pred(input string name, input logic t, input logic [31:0] tgt);
        expect_val({name, "_taken"}, c_K_PT, {31'd0, t});
        expect_val({name, "_target"}, c_K_TG, tgt);
    endtask

    task automatic expect_stats(input string name, input logic [31:0] br, input logic [31:0] mp);
        expect_val({name, "_branches"}, c_K_SB, br);
        expect_val({name, "_mispredicts"}, c_K_SM, mp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_pc          = pc;
        ex_taken       = t;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        if_pc = 32'h100;
        idle_ex();
        ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
        #2;
        expect_pred("reset_pred", 1'b0, 32'h104);
        expect_stats("reset", 32'd0, 32'd0);
        repeat (2) cyc();
        rstn = 1'b1;
        cyc();

        // First taken resolve at 0x100 allocates and mispredicts.
        resolve(32'h100, 1'b1, 32'h080, 1'b0, 32'h104);
        expect_val("alloc_mispredict", c_K_MP, 32'd1);
        expect_val("alloc_redirect", c_K_RD, 32'h080);
        expect_pred("alloc_same_cycle", 1'b0, 32'h104);
        cyc();
        idle_ex();
        expect_pred("alloc_next", 1'b1, 32'h080);
        expect_stats("alloc", 32'd1, 32'd1);
        cyc();

        // Saturate to strongly taken, then decay one step at a time.
        resolve(32'h100, 1'b1, 32'h080, 1'b1, 32'h080);
        expect_val("correct_taken_mp", c_K_MP, 32'd0);
        cyc();
        cyc();
        idle_ex();
        expect_pred("st_pred", 1'b1, 32'h080);
        expect_stats("st", 32'd3, 32'd1);
        cyc();
        resolve(32'h100, 1'b0, 32'h080, 1'b1, 32'h080);
        expect_val("nt1_mispredict", c_K_MP, 32'd1);
        expect_val("nt1_redirect", c_K_RD, 32'h104);
        cyc();
        idle_ex();
        expect_pred("hyst_wt", 1'b1, 32'h080);
        cyc();
        resolve(32'h100, 1'b0, 32'h080, 1'b1, 32'h080);
        cyc();
        idle_ex();
        expect_pred("hyst_wnt", 1'b0, 32'h104);
        expect_stats("hyst", 32'd5, 32'd3);
        cyc();

        // Retrain 0x100, then evict it with aliasing 0x200.
        resolve(32'h100, 1'b1, 32'h080, 1'b0, 32'h104);
        cyc();
        idle_ex();
        expect_pred("retrain", 1'b1, 32'h080);
        cyc();
        resolve(32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        expect_val("alias_mispredict", c_K_MP, 32'd1);
        cyc();
        idle_ex();
        expect_pred("alias_old_miss", 1'b0, 32'h104);
        cyc();
        if_pc = 32'h200;
        expect_pred("alias_new_hit", 1'b1, 32'h300);
        expect_stats("alias", 32'd7, 32'd5);
        cyc();

        // Correct direction but wrong target still redirects.
        resolve(32'h140, 1'b1, 32'h080, 1'b0, 32'h144);
        cyc();
        resolve(32'h140, 1'b1, 32'h0C0, 1'b1, 32'h080);
        expect_val("tgt_mispredict", c_K_MP, 32'd1);
        expect_val("tgt_redirect", c_K_RD, 32'h0C0);
        cyc();
        idle_ex();
        if_pc = 32'h140;
        expect_pred("tgt_updated", 1'b1, 32'h0C0);
        expect_stats("tgt", 32'd9, 32'd7);
        cyc();

        // Not-taken miss leaves the table alone; PC+4 wraps at the top.
        resolve(32'h180, 1'b0, 32'h000, 1'b0, 32'h184);
        expect_val("ntmiss_mispredict", c_K_MP, 32'd0);
        expect_val("ntmiss_redirect", c_K_RD, 32'h184);
        if_pc = 32'hFFFF_FFFC;
        expect_pred("wrap", 1'b0, 32'h0000_0000);
        cyc();
        idle_ex();
        if_pc = 32'h180;
        expect_pred("ntmiss_nochange", 1'b0, 32'h184);
        expect_val("ntmiss_branches", c_K_SB, 32'd10);
        cyc();

        // Same-cycle read and write at one index: IF sees the old entry.
        if_pc = 32'h140;
        resolve(32'h140, 1'b1, 32'h100, 1'b1, 32'h0C0);
        expect_pred("collide_old", 1'b1, 32'h0C0);
        cyc();
        idle_ex();
        expect_pred("collide_new", 1'b1, 32'h100);
        expect_stats("collide", 32'd11, 32'd8);
        cyc();

        // Asynchronous reset in the middle of an update.
        resolve(32'h140, 1'b1, 32'h200, 1'b1, 32'h100);
        #1;
        rstn = 1'b0;
        #1;
        expect_pred("async_rst_pred", 1'b0, 32'h144);
        expect_stats("async_rst", 32'd0, 32'd0);
        cyc();
        idle_ex();
        rstn = 1'b1;
        cyc();
        expect_pred("post_rst_140", 1'b0, 32'h144);
        expect_stats("post_rst", 32'd0, 32'd0);
        cyc();
        if_pc = 32'h200;
        expect_pred("post_rst_200", 1'b0, 32'h204);
        cyc();
        cyc();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
